// File: rtl/servo_pkg.sv
// servo_pkg: shared widths, timing constants and FSM encoding for servoscan_ctrl
package servo_pkg;
   localparam int CNT_W     = 7;
   localparam int NUM_CH    = 2;
   localparam int SCAN_LEN  = CNT_W * NUM_CH;
   localparam int QUIET_CYC = 200;
   localparam int MAX_HIGH  = 4000;
   localparam int HI_W      = 12;
   localparam int QC_W      = 8;
   localparam int SC_W      = 4;
   typedef enum logic [2:0] {FLUSH_INIT, ARMED, QUIET, SCAN, LOAD} state_t;
endpackage

// File: rtl/servo_sync.sv
// servo_sync: 2-flop synchroniser with synced rising-edge detect
module servo_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise
);
   logic [2:0] sr;
   always_ff @(posedge clk)
      if (rst) sr <= '0;
      else sr <= {sr[1:0], din};
   assign sync = sr[1];
   assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/servoscan_ctrl.sv
// servoscan_ctrl: sequences servocount scans and hands captured widths downstream
module servoscan_ctrl
   import servo_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in0,
   input  logic             in1,
   input  logic             scan_out,
   output logic             scan_en,
   output logic [CNT_W-1:0] ch0_width,
   output logic [CNT_W-1:0] ch1_width,
   output logic [1:0]       sat,
   output logic             stuck,
   output logic             overrun,
   output logic             valid,
   input  logic             ready
);
   state_t state, next_state;
   logic [NUM_CH-1:0] sync, rise, timeout, fired;
   logic [HI_W-1:0] hi_cnt [NUM_CH];
   logic [QC_W-1:0] quiet_cnt;
   logic [SC_W-1:0] scan_cnt;
   logic [SCAN_LEN-1:0] sr;
   logic seen_hi, stuck_pend, scan_done, take_timeout, load, scan_en_d;
   servo_sync u_sync0 (.clk(clk), .rst(rst), .din(in0), .sync(sync[0]), .rise(rise[0]));
   servo_sync u_sync1 (.clk(clk), .rst(rst), .din(in1), .sync(sync[1]), .rise(rise[1]));
   // fired latches a taken timeout so a line held high cannot retrigger until it drops
   always_comb
      for (int i = 0; i < NUM_CH; i++)
         timeout[i] = hi_cnt[i] == HI_W'(MAX_HIGH) && !fired[i];
   always_ff @(posedge clk)
      for (int i = 0; i < NUM_CH; i++)
         if (rst || !sync[i]) begin
            hi_cnt[i] <= '0;
            fired[i] <= 1'b0;
         end else begin
            hi_cnt[i] <= hi_cnt[i] + HI_W'(hi_cnt[i] != HI_W'(MAX_HIGH));
            fired[i] <= fired[i] | (take_timeout & timeout[i]);
         end
   assign take_timeout = (state == ARMED || state == QUIET) && |timeout;
   assign scan_done = scan_en && scan_cnt == SC_W'(SCAN_LEN - 1);
   always_comb begin
      next_state = state;
      case (state)
         FLUSH_INIT: next_state = scan_done ? ARMED : FLUSH_INIT;
         ARMED:      next_state = take_timeout ? SCAN : (seen_hi && !(|sync)) ? QUIET : ARMED;
         QUIET:      next_state = take_timeout ? SCAN : (|sync) ? ARMED :
                                  quiet_cnt == QC_W'(QUIET_CYC - 1) ? SCAN : QUIET;
         SCAN:       next_state = scan_done ? LOAD : SCAN;
         default:    next_state = ARMED;
      endcase
   end
   always_comb begin
      scan_en_d = next_state == FLUSH_INIT || next_state == SCAN;
      load = state == LOAD;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= FLUSH_INIT;
         scan_en <= 1'b0;
         scan_cnt <= '0;
         quiet_cnt <= '0;
         sr <= '0;
         seen_hi <= 1'b0;
         stuck_pend <= 1'b0;
      end else begin
         state <= next_state;
         scan_en <= scan_en_d;
         scan_cnt <= scan_done ? '0 : scan_cnt + SC_W'(scan_en);
         quiet_cnt <= state == QUIET ? quiet_cnt + QC_W'(1) : '0;
         sr <= scan_en ? {sr[SCAN_LEN-2:0], scan_out} : sr;
         seen_hi <= (seen_hi & ~load) | (|rise);
         stuck_pend <= (stuck_pend & ~load) | take_timeout;
      end
   always_ff @(posedge clk)
      if (rst) begin
         ch0_width <= '0;
         ch1_width <= '0;
         sat <= '0;
         stuck <= 1'b0;
         overrun <= 1'b0;
         valid <= 1'b0;
      end else if (load) begin
         ch0_width <= sr[SCAN_LEN-1 -: CNT_W];
         ch1_width <= sr[CNT_W-1:0];
         sat <= {&sr[CNT_W-1:0], &sr[SCAN_LEN-1 -: CNT_W]};
         stuck <= stuck_pend;
         overrun <= valid & ~ready;
         valid <= 1'b1;
      end else if (valid && ready) begin
         valid <= 1'b0;
         overrun <= 1'b0;
      end
endmodule

// File: tb/tb_servoscan_ctrl.sv
// tb_servoscan_ctrl: directed checks of flush, quiet timing, stuck timeout, saturation and handshake
module tb_servoscan_ctrl;
   logic clk = 1'b0, rst = 1'b1, in0 = 1'b0, in1 = 1'b0, ready = 1'b0;
   logic scan_en, scan_out, valid, stuck, overrun;
   logic [6:0] ch0_width, ch1_width;
   logic [1:0] sat;
   logic [13:0] frame_word = '0;
   int k = 0, xfers = 0, n_chk = 0, n_fail = 0, scan_seen = 0;
   always #5 clk = ~clk;
   servoscan_ctrl dut (
      .clk(clk), .rst(rst), .in0(in0), .in1(in1), .scan_out(scan_out), .scan_en(scan_en),
      .ch0_width(ch0_width), .ch1_width(ch1_width), .sat(sat), .stuck(stuck),
      .overrun(overrun), .valid(valid), .ready(ready)
   );
   // servocount model: shifts the loaded frame out MSB first while scan_en is high
   assign scan_out = (k < 14) ? frame_word[13 - k] : 1'b0;
   always @(posedge clk) begin
      k <= scan_en ? k + 1 : 0;
      if (valid && ready) xfers <= xfers + 1;
   end
   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         tick();
         if (scan_en) scan_seen++;
      end
   endtask
   task automatic wait_scan(output int dly);
      dly = -1;
      for (int i = 1; i <= 5000; i++) begin
         tick();
         if (scan_en) begin
            dly = i;
            break;
         end
      end
   endtask
   task automatic measure_scan(output int dly, output int len);
      wait_scan(dly);
      len = 0;
      if (dly > 0) begin
         len = 1;
         while (scan_en && len < 40) begin
            tick();
            if (scan_en) len++;
         end
      end
   endtask
   task automatic wait_valid(output int n);
      n = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (valid) begin
            n = i;
            break;
         end
      end
   endtask
   task automatic expect_frame(input string tag, input int exp_dly, input logic [13:0] w,
                               input int exp_sat, input int exp_stuck, input int exp_ovr);
      int d, l, v;
      frame_word = w;
      measure_scan(d, l);
      check({tag, "_scan_dly"}, d, exp_dly);
      check({tag, "_scan_len"}, l, 14);
      wait_valid(v);
      check({tag, "_load_lat"}, v, 1);
      check({tag, "_ch0"}, int'(ch0_width), int'(w[13:7]));
      check({tag, "_ch1"}, int'(ch1_width), int'(w[6:0]));
      check({tag, "_sat"}, int'(sat), exp_sat);
      check({tag, "_stuck"}, int'(stuck), exp_stuck);
      check({tag, "_overrun"}, int'(overrun), exp_ovr);
   endtask
   task automatic accept(input string tag);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check({tag, "_xfer_valid"}, int'(valid), 0);
   endtask
   initial begin
      int d, l, x0;
      repeat (3) tick();
      check("rst_scan_en", int'(scan_en), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_ch0", int'(ch0_width), 0);
      check("rst_sat", int'(sat), 0);
      check("rst_overrun", int'(overrun), 0);
      rst = 1'b0;
      measure_scan(d, l);
      check("flush_dly", d, 1);
      check("flush_len", l, 14);
      idle(20);
      check("flush_valid", int'(valid), 0);
      // in0 1835 cycles, in1 overlapping its end for 240 cycles
      scan_seen = 0;
      in0 = 1'b1;
      idle(1700);
      in1 = 1'b1;
      idle(135);
      in0 = 1'b0;
      idle(105);
      in1 = 1'b0;
      check("norm_no_early_scan", scan_seen, 0);
      expect_frame("norm", 203, {7'h5B, 7'h0F}, 0, 0, 0);
      accept("norm");
      scan_seen = 0;
      in0 = 1'b1;
      idle(500);
      in0 = 1'b0;
      idle(102);
      in1 = 1'b1;
      idle(50);
      in1 = 1'b0;
      check("qr_no_early_scan", scan_seen, 0);
      expect_frame("qr", 203, {7'h12, 7'h34}, 0, 0, 0);
      accept("qr");
      in0 = 1'b1;
      expect_frame("stuck", 4003, {7'h40, 7'h01}, 0, 1, 0);
      accept("stuck");
      scan_seen = 0;
      idle(900);
      check("stuck_no_retrig", scan_seen, 0);
      in0 = 1'b0;
      idle(300);
      check("stuck_release_no_scan", scan_seen, 0);
      in1 = 1'b1;
      idle(300);
      in1 = 1'b0;
      expect_frame("sat", 203, {7'h05, 7'h7F}, 2, 0, 0);
      accept("sat");
      x0 = xfers;
      in0 = 1'b1;
      idle(100);
      in0 = 1'b0;
      expect_frame("bpA", 203, {7'h11, 7'h22}, 0, 0, 0);
      idle(50);
      check("bpA_hold_valid", int'(valid), 1);
      check("bpA_hold_ch0", int'(ch0_width), 'h11);
      in1 = 1'b1;
      idle(100);
      in1 = 1'b0;
      expect_frame("bpB", 203, {7'h33, 7'h44}, 0, 0, 1);
      ready = 1'b1;
      tick();
      check("bp_valid_drop", int'(valid), 0);
      check("bp_overrun_clear", int'(overrun), 0);
      idle(10);
      ready = 1'b0;
      check("bp_one_xfer", xfers - x0, 1);
      in0 = 1'b1;
      idle(100);
      in0 = 1'b0;
      wait_scan(d);
      check("mrst_scan_dly", d, 203);
      idle(5);
      rst = 1'b1;
      tick();
      check("mrst_scan_en_drop", int'(scan_en), 0);
      check("mrst_valid", int'(valid), 0);
      rst = 1'b0;
      measure_scan(d, l);
      check("mrst_flush_dly", d, 1);
      check("mrst_flush_len", l, 14);
      idle(20);
      check("mrst_flush_valid", int'(valid), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
